// File: rtl/m_out_collect_pkg.sv
// Shared parameters, FSM state type and helpers for the output collector.
package m_out_collect_pkg;

    localparam int OC_LANES   = 8;
    localparam int OC_PSUM_W  = 24;
    localparam int OC_ACC_W   = 32;
    localparam int OC_OADDR_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN,
        ST_DONE
    } oc_state_e;

    // Each set shift bit moves the term up one nibble.
    function automatic logic [3:0] shift_amt(input logic [1:0] s);
        logic [3:0] n;
        n = {3'b000, s[0]} + {3'b000, s[1]};
        return n << 2;
    endfunction

endpackage

// File: rtl/m_out_queue.sv
// Two-entry write queue between the accumulator and the output buffer.
// Entry 0 is always the head; simultaneous push/pop is allowed when full.
module m_out_queue #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop_ok;
    logic         push_ok;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        pop_ok  = pop && (cnt_q != 2'd0);
        push_ok = push && ((cnt_q != 2'd2) || pop_ok);
        case ({push_ok, pop_ok})
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = wdata;
                end else begin
                    e0_d = e1_q;
                    e1_d = wdata;
                end
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    e0_d = wdata;
                end else begin
                    e1_d = wdata;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = e0_q;
    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'd2);

endmodule

// File: rtl/m_out_collect.sv
// Output collector: accumulates shifted partial sums per lane and writes
// finished output words to the banked output buffer through a small queue.
module m_out_collect
    import m_out_collect_pkg::*;
#(
    parameter int LANES   = OC_LANES,
    parameter int PSUM_W  = OC_PSUM_W,
    parameter int ACC_W   = OC_ACC_W,
    parameter int OADDR_W = OC_OADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*PSUM_W-1:0]   in_psum,
    input  logic [1:0]                in_shift,
    input  logic                      in_out,
    input  logic                      in_tile_last,
    input  logic [LANES-1:0]          in_bank_sel,
    input  logic [OADDR_W-1:0]        in_addr,
    output logic [LANES-1:0]          obuf_wen,
    output logic [OADDR_W-1:0]        obuf_waddr,
    output logic [LANES*ACC_W-1:0]    obuf_wdata,
    input  logic                      obuf_ready,
    output logic                      done,
    output logic [15:0]               wr_count
);

    localparam int QW = LANES*ACC_W + LANES + OADDR_W;

    oc_state_e state_q, state_d;

    logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [LANES-1:0][ACC_W-1:0] acc_next;
    logic [ACC_W-1:0]            term [LANES];
    logic [ACC_W:0]              sum  [LANES];
    logic                        first_q, first_d;
    logic                        rdy_en_q, rdy_en_d;
    logic [15:0]                 wr_cnt_q, wr_cnt_d;

    logic          accept;
    logic          q_push;
    logic          q_pop;
    logic          q_empty;
    logic          q_full;
    logic [QW-1:0] q_wdata;
    logic [QW-1:0] q_head;
    logic [3:0]    sh;

    assign sh = shift_amt(in_shift);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            term[i] = ACC_W'(signed'(in_psum[i*PSUM_W +: PSUM_W])) << sh;
            sum[i]  = {acc_q[i][ACC_W-1], acc_q[i]} + {term[i][ACC_W-1], term[i]};
            if (first_q) begin
                acc_next[i] = term[i];
            end else if (sum[i][ACC_W] != sum[i][ACC_W-1]) begin
                // Overflow: clamp toward the sign of the true result.
                acc_next[i] = sum[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                            : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                acc_next[i] = sum[i][ACC_W-1:0];
            end
        end
    end

    assign q_pop    = !q_empty && obuf_ready;
    assign in_ready = rdy_en_q
                   && ((state_q == ST_IDLE) || (state_q == ST_ACC))
                   && (!q_full || q_pop);
    assign accept   = in_valid && in_ready;
    assign q_push   = accept && in_out && (in_bank_sel != '0);
    assign q_wdata  = {acc_next, in_bank_sel, in_addr};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        first_d  = first_q;
        rdy_en_d = 1'b1;
        wr_cnt_d = wr_cnt_q;
        if (accept) begin
            acc_d   = acc_next;
            first_d = in_out;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (in_out && in_tile_last) ? ST_DRAIN : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept && in_out && in_tile_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (q_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_q == ST_IDLE) && accept) begin
            wr_cnt_d = '0;
        end else if (q_pop && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            first_q  <= 1'b1;
            rdy_en_q <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            first_q  <= first_d;
            rdy_en_q <= rdy_en_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    m_out_queue #(
        .W(QW)
    ) u_q (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .head  (q_head),
        .empty (q_empty),
        .full  (q_full)
    );

    assign obuf_waddr = q_head[OADDR_W-1:0];
    assign obuf_wen   = q_empty ? '0 : q_head[OADDR_W +: LANES];
    assign obuf_wdata = q_head[QW-1 -: LANES*ACC_W];
    assign done       = (state_q == ST_DONE);
    assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_m_out_collect.sv
// Directed testbench for m_out_collect with default parameters.
module tb_m_out_collect;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [191:0] in_psum;
    logic [1:0]   in_shift;
    logic         in_out;
    logic         in_tile_last;
    logic [7:0]   in_bank_sel;
    logic [5:0]   in_addr;
    logic [7:0]   obuf_wen;
    logic [5:0]   obuf_waddr;
    logic [255:0] obuf_wdata;
    logic         obuf_ready;
    logic         done;
    logic [15:0]  wr_count;

    int total = 0;
    int bad   = 0;

    m_out_collect dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_psum      (in_psum),
        .in_shift     (in_shift),
        .in_out       (in_out),
        .in_tile_last (in_tile_last),
        .in_bank_sel  (in_bank_sel),
        .in_addr      (in_addr),
        .obuf_wen     (obuf_wen),
        .obuf_waddr   (obuf_waddr),
        .obuf_wdata   (obuf_wdata),
        .obuf_ready   (obuf_ready),
        .done         (done),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [23:0] p0, input logic [23:0] p1,
                        input logic [1:0] sh, input logic o, input logic tl,
                        input logic [7:0] bs, input logic [5:0] ad);
        in_psum         = '0;
        in_psum[23:0]   = p0;
        in_psum[47:24]  = p1;
        in_shift        = sh;
        in_out          = o;
        in_tile_last    = tl;
        in_bank_sel     = bs;
        in_addr         = ad;
        in_valid        = 1'b1;
    endtask

    task automatic idle_in;
        in_valid     = 1'b0;
        in_out       = 1'b0;
        in_tile_last = 1'b0;
        in_psum      = '0;
    endtask

    task automatic wait_done(output int pulses);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) pulses++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_in();
        in_shift = 2'd0; in_bank_sel = '0; in_addr = '0; obuf_ready = 1'b0;
        tick(); tick();
        total++;
        if (in_ready !== 1'b0 || obuf_wen !== 8'h00 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: ready=%b wen=%h done=%b, want 0/00/0",
                     in_ready, obuf_wen, done);
        end
        total++;
        if (obuf_waddr !== 6'd0 || obuf_wdata !== '0 || wr_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_data: waddr=%0d wdata=%h cnt=%0d, want 0",
                     obuf_waddr, obuf_wdata, wr_count);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_early: got %b want 0", in_ready);
        end
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_rise: got %b want 1", in_ready);
        end
    endtask

    task automatic test_normal;
        obuf_ready = 1'b1;
        beat(24'd5, 24'd0, 2'd0, 1'b1, 1'b1, 8'h01, 6'd3);
        tick();
        idle_in();
        total++;
        if (obuf_wen !== 8'h01 || obuf_waddr !== 6'd3 || obuf_wdata[31:0] !== 32'd5) begin
            bad++;
            $display("FAIL normal_write: wen=%h addr=%0d d0=%h, want 01/3/5",
                     obuf_wen, obuf_waddr, obuf_wdata[31:0]);
        end
        tick();
        total++;
        if (obuf_wen !== 8'h00 || wr_count !== 16'd1 || done !== 1'b0) begin
            bad++;
            $display("FAIL normal_pop: wen=%h cnt=%0d done=%b, want 00/1/0",
                     obuf_wen, wr_count, done);
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL normal_done: got %b want 1", done);
        end
        tick();
        total++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL normal_idle: done=%b ready=%b, want 0/1", done, in_ready);
        end
    endtask

    task automatic test_outlier;
        int p;
        obuf_ready = 1'b1;
        beat(24'd1, 24'hFFFFFF, 2'd0, 1'b0, 1'b0, 8'h03, 6'd7);
        tick();
        beat(24'd1, 24'hFFFFFF, 2'd1, 1'b0, 1'b0, 8'h03, 6'd7);
        tick();
        beat(24'd1, 24'hFFFFFF, 2'd2, 1'b0, 1'b0, 8'h03, 6'd7);
        tick();
        beat(24'd1, 24'hFFFFFF, 2'd3, 1'b1, 1'b1, 8'h03, 6'd7);
        tick();
        idle_in();
        total++;
        if (obuf_wen !== 8'h03 || obuf_waddr !== 6'd7 || obuf_wdata[31:0] !== 32'd289) begin
            bad++;
            $display("FAIL outlier_sum: wen=%h addr=%0d d0=%0d, want 03/7/289",
                     obuf_wen, obuf_waddr, obuf_wdata[31:0]);
        end
        total++;
        if (obuf_wdata[63:32] !== 32'hFFFFFEDF) begin
            bad++;
            $display("FAIL outlier_neg: got %h want FFFFFEDF", obuf_wdata[63:32]);
        end
        wait_done(p);
        total++;
        if (p != 1 || wr_count !== 16'd1) begin
            bad++;
            $display("FAIL outlier_done: pulses=%0d cnt=%0d, want 1/1", p, wr_count);
        end
    endtask

    task automatic test_backpressure;
        int p;
        obuf_ready = 1'b0;
        beat(24'd2, 24'd0, 2'd0, 1'b1, 1'b0, 8'h01, 6'd10);
        tick();
        beat(24'd3, 24'd0, 2'd0, 1'b1, 1'b0, 8'h01, 6'd11);
        tick();
        beat(24'd4, 24'd0, 2'd0, 1'b1, 1'b1, 8'h01, 6'd12);
        #1;
        total++;
        if (in_ready !== 1'b0 || obuf_waddr !== 6'd10) begin
            bad++;
            $display("FAIL bp_stall: ready=%b addr=%0d, want 0/10", in_ready, obuf_waddr);
        end
        tick();
        total++;
        if (in_ready !== 1'b0 || obuf_waddr !== 6'd10 || obuf_wen !== 8'h01
            || obuf_wdata[31:0] !== 32'd2) begin
            bad++;
            $display("FAIL bp_hold: ready=%b addr=%0d wen=%h d0=%0d, want 0/10/01/2",
                     in_ready, obuf_waddr, obuf_wen, obuf_wdata[31:0]);
        end
        obuf_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got %b want 1", in_ready);
        end
        tick();
        idle_in();
        total++;
        if (obuf_waddr !== 6'd11 || obuf_wdata[31:0] !== 32'd3) begin
            bad++;
            $display("FAIL bp_second: addr=%0d d0=%0d, want 11/3", obuf_waddr, obuf_wdata[31:0]);
        end
        tick();
        total++;
        if (obuf_waddr !== 6'd12 || obuf_wdata[31:0] !== 32'd4) begin
            bad++;
            $display("FAIL bp_third: addr=%0d d0=%0d, want 12/4", obuf_waddr, obuf_wdata[31:0]);
        end
        wait_done(p);
        total++;
        if (p != 1 || wr_count !== 16'd3) begin
            bad++;
            $display("FAIL bp_done: pulses=%0d cnt=%0d, want 1/3", p, wr_count);
        end
    endtask

    task automatic test_saturation;
        int p;
        obuf_ready = 1'b1;
        beat(24'h7FFFFF, 24'h800000, 2'd3, 1'b0, 1'b0, 8'h03, 6'd20);
        tick();
        beat(24'h7FFFFF, 24'h800000, 2'd3, 1'b1, 1'b1, 8'h03, 6'd20);
        tick();
        idle_in();
        total++;
        if (obuf_wdata[31:0] !== 32'h7FFFFFFF) begin
            bad++;
            $display("FAIL sat_pos: got %h want 7FFFFFFF", obuf_wdata[31:0]);
        end
        total++;
        if (obuf_wdata[63:32] !== 32'h80000000) begin
            bad++;
            $display("FAIL sat_neg: got %h want 80000000", obuf_wdata[63:32]);
        end
        wait_done(p);
    endtask

    task automatic test_back_to_back;
        int p;
        obuf_ready = 1'b0;
        beat(24'd1, 24'd0, 2'd0, 1'b1, 1'b0, 8'h01, 6'd1);
        tick();
        beat(24'd2, 24'd0, 2'd0, 1'b1, 1'b0, 8'h01, 6'd2);
        tick();
        beat(24'd3, 24'd0, 2'd0, 1'b1, 1'b0, 8'h01, 6'd3);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_full: ready=%b want 0", in_ready);
        end
        obuf_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || obuf_waddr !== 6'd1) begin
            bad++;
            $display("FAIL b2b_pushpop: ready=%b addr=%0d, want 1/1", in_ready, obuf_waddr);
        end
        tick();
        idle_in();
        obuf_ready = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || obuf_waddr !== 6'd2 || obuf_wdata[31:0] !== 32'd2) begin
            bad++;
            $display("FAIL b2b_count: ready=%b addr=%0d d0=%0d, want 0/2/2",
                     in_ready, obuf_waddr, obuf_wdata[31:0]);
        end
        obuf_ready = 1'b1;
        tick();
        total++;
        if (obuf_wen !== 8'h01 || obuf_waddr !== 6'd3 || obuf_wdata[31:0] !== 32'd3) begin
            bad++;
            $display("FAIL b2b_order: wen=%h addr=%0d d0=%0d, want 01/3/3",
                     obuf_wen, obuf_waddr, obuf_wdata[31:0]);
        end
        tick();
        beat(24'd9, 24'd0, 2'd0, 1'b1, 1'b1, 8'h00, 6'd9);
        tick();
        idle_in();
        total++;
        if (obuf_wen !== 8'h00) begin
            bad++;
            $display("FAIL b2b_nobank: wen=%h want 00", obuf_wen);
        end
        wait_done(p);
        total++;
        if (p != 1 || wr_count !== 16'd3) begin
            bad++;
            $display("FAIL b2b_done: pulses=%0d cnt=%0d, want 1/3", p, wr_count);
        end
    endtask

    task automatic test_reset_mid;
        int p;
        int w;
        obuf_ready = 1'b0;
        beat(24'd1, 24'd0, 2'd0, 1'b1, 1'b0, 8'h01, 6'd4);
        tick();
        beat(24'd2, 24'd0, 2'd0, 1'b1, 1'b1, 8'h01, 6'd5);
        tick();
        idle_in();
        total++;
        if (obuf_wen !== 8'h01) begin
            bad++;
            $display("FAIL rm_queued: wen=%h want 01", obuf_wen);
        end
        rst = 1'b1;
        #1;
        total++;
        if (obuf_wen !== 8'h00 || wr_count !== 16'd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rm_flush: wen=%h cnt=%0d ready=%b, want 00/0/0",
                     obuf_wen, wr_count, in_ready);
        end
        tick();
        rst = 1'b0;
        obuf_ready = 1'b1;
        p = 0;
        w = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) p++;
            if (obuf_wen != 8'h00) w++;
        end
        total++;
        if (p != 0 || w != 0 || wr_count !== 16'd0) begin
            bad++;
            $display("FAIL rm_quiet: done_pulses=%0d writes=%0d cnt=%0d, want 0/0/0",
                     p, w, wr_count);
        end
        beat(24'd100, 24'd0, 2'd0, 1'b0, 1'b0, 8'h01, 6'd2);
        tick();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        beat(24'd7, 24'd0, 2'd0, 1'b1, 1'b1, 8'h01, 6'd2);
        tick();
        idle_in();
        total++;
        if (obuf_wdata[31:0] !== 32'd7 || obuf_wen !== 8'h01) begin
            bad++;
            $display("FAIL rm_partial: d0=%0d wen=%h, want 7/01", obuf_wdata[31:0], obuf_wen);
        end
        wait_done(p);
        total++;
        if (p != 1 || wr_count !== 16'd1) begin
            bad++;
            $display("FAIL rm_after: pulses=%0d cnt=%0d, want 1/1", p, wr_count);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_outlier();
        test_backpressure();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/m_out_collect.md
M_OUT_COLLECT -- requirements
Module: m_out_collect

Interface
REQ-001 Parameter LANES, default 8, number of output-buffer banks and partial-sum lanes.
REQ-002 Parameter PSUM_W, default 24, signed partial-sum width per lane from the multiply array.
REQ-003 Parameter ACC_W, default 32, signed accumulator and write-data width per lane.
REQ-004 Parameter OADDR_W, default 6, output-buffer address width.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  array result beat valid.
REQ-008 in_ready  out  1  beat accepted when in_valid and in_ready are both high.
REQ-009 in_psum  in  LANES*PSUM_W  per-lane signed partial sums, lane 0 in the LSBs.
REQ-010 in_shift  in  2  outlier sub-pass weight, bit0 = W high nibble, bit1 = A high nibble.
REQ-011 in_out  in  1  last sub-pass of this output word; the result is written.
REQ-012 in_tile_last  in  1  last output word of the instruction.
REQ-013 in_bank_sel  in  LANES  lanes to write.
REQ-014 in_addr  in  OADDR_W  output-buffer word address.
REQ-015 obuf_wen  out  LANES  per-bank write enable.
REQ-016 obuf_waddr  out  OADDR_W  write address.
REQ-017 obuf_wdata  out  LANES*ACC_W  write data.
REQ-018 obuf_ready  in  1  buffer accepts the write this cycle; the write completes only when obuf_wen is nonzero and obuf_ready is high.
REQ-019 done  out  1  one-cycle pulse: all writes of the instruction have completed (drives mFinish).
REQ-020 wr_count  out  16  completed writes since the last IDLE-to-ACC transition, saturating at 0xFFFF.

Function
REQ-021 FSM states: IDLE, ACC, DRAIN, DONE.
REQ-022 IDLE goes to ACC on an accepted beat.
REQ-023 ACC goes to DRAIN on an accepted beat that has both in_out and in_tile_last set.
REQ-024 DRAIN goes to DONE when the queue is empty; done=1 in DONE only; DONE goes to IDLE the next cycle.
REQ-025 in_ready = (state is IDLE or ACC) AND (queue not full OR queue pop this cycle).
REQ-026 Per-lane term = sign-extend(psum) shifted left by 4*(in_shift[0]+in_shift[1]) bits.
REQ-027 On an accepted beat, acc_next = term when the first flag is set, otherwise acc + term; the first flag is 1 after reset and after every accepted in_out beat.
REQ-028 The addition saturates to the signed ACC_W range; it does not wrap.
REQ-029 An accepted beat with in_out set pushes {acc_next, in_bank_sel, in_addr} into the queue on the same edge; the earliest write is on the following cycle.
REQ-030 in_bank_sel = 0 with in_out set pushes nothing, and neither the write count nor the queue changes.
REQ-031 The queue has 2 entries.
REQ-032 The queue head drives obuf_waddr and obuf_wdata.
REQ-033 obuf_wen = head bank_sel while the queue is non-empty, and 0 otherwise.
REQ-034 The queue pops on obuf_ready.
REQ-035 A push and a pop in the same cycle on a full queue are legal; the count is unchanged.
REQ-036 obuf_waddr and obuf_wdata hold stable while obuf_wen is nonzero and obuf_ready is low.
REQ-037 wr_count increments on each pop and clears on the IDLE-to-ACC transition.

Reset
REQ-038 While rst is high: state=IDLE, acc=0, first=1, queue empty, in_ready=0, obuf_wen=0, obuf_waddr=0, obuf_wdata=0, done=0, wr_count=0.
REQ-039 Reset asserted mid-instruction discards queued writes and the partial accumulation.
REQ-040 in_ready rises one cycle after rst deasserts.

Structure
REQ-041 LANES, PSUM_W, ACC_W, OADDR_W and the FSM enum type belong in the Common package.
REQ-042 The 2-entry queue is the sub-module m_out_queue; accumulation and the FSM stay in m_out_collect.

Verification
REQ-043 Normal sub-pass: one beat, lane0 psum=5, shift=0, out=1, tile_last=1, bank_sel=0x01, addr=3, obuf_ready=1 -> next cycle obuf_wen=0x01, waddr=3, wdata lane0=5; two cycles later done pulses once; wr_count=1.
REQ-044 Outlier sub-passes: four beats, psum=1, shift=0,1,2,3, out only on the last -> written value 1+16+16+256=289.
REQ-045 Backpressure and saturation: obuf_ready=0 while three out-beats arrive -> the third beat stalls with in_ready=0 and waddr holds; a lane accumulating 0x7FFFFF<<8 twice -> 0x7FFFFFFF.
REQ-046 Full queue, simultaneous push and pop: queue full, obuf_ready=1 and a new out-beat in the same cycle -> beat accepted, count stays 2, write order preserved.
REQ-047 Reset mid-DRAIN: two queued writes, then rst pulsed -> obuf_wen=0 immediately, done never pulses, wr_count=0.
